// File: rtl/m_st7789_rx.sv
// ST7789 3-wire SPI receiver: deserialises SCL/SDA/DC, decodes the panel command subset and
// emits RGB565 framebuffer writes. Define ST7789_RX_MADCTL_EN to apply MADCTL to the write address.
`timescale 1ns/1ps

module m_st7789_rx #(
  parameter int IDLE_CYC = 32
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        st7789_SDA,
  input  logic        st7789_SCL,
  input  logic        st7789_DC,
  input  logic        st7789_RES,
  output logic        w_we,
  output logic [15:0] w_waddr,
  output logic [15:0] w_wdata,
  output logic        w_sleep,
  output logic        w_disp_on,
  output logic        w_inv,
  output logic        w_err
);

  localparam int          IW     = $clog2(IDLE_CYC) + 1;
  localparam logic [15:0] MAX_XY = 16'd239;

  typedef enum logic [1:0] {S_IDLE, S_PARAM, S_RAMWR_HI, S_RAMWR_LO} state_t;

  // ---------------- input capture ----------------
  logic [3:0] r_sync1, r_sync2;
  logic       r_scl_prev;
  logic       w_sda, w_scl, w_dc, w_res_n, w_fall;

  assign {w_res_n, w_dc, w_scl, w_sda} = r_sync2;
  assign w_fall = r_scl_prev & ~w_scl;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      // NOTE: SCL resets to its idle-high level so leaving reset never fakes a falling edge.
      r_sync1    <= 4'b0010;
      r_sync2    <= 4'b0010;
      r_scl_prev <= 1'b1;
    end else begin
      r_sync1    <= {st7789_RES, st7789_DC, st7789_SCL, st7789_SDA};
      r_sync2    <= r_sync1;
      r_scl_prev <= w_scl;
    end
  end

  // ---------------- bit shifter with idle abort ----------------
  logic [6:0]    r_shift;
  logic [7:0]    r_byte;
  logic [2:0]    r_bitcnt;
  logic [IW-1:0] r_idle;
  logic          r_byte_vld, r_byte_dc, r_abort;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_shift    <= '0;
      r_byte     <= '0;
      r_bitcnt   <= '0;
      r_idle     <= '0;
      r_byte_vld <= 1'b0;
      r_byte_dc  <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_abort    <= 1'b0;
      if (!w_res_n) begin
        r_bitcnt <= '0;
        r_idle   <= '0;
      end else if (w_fall) begin
        r_shift  <= {r_shift[5:0], w_sda};
        r_bitcnt <= r_bitcnt + 3'd1;
        r_idle   <= '0;
        if (r_bitcnt == 3'd7) begin
          r_byte     <= {r_shift, w_sda};
          r_byte_dc  <= w_dc;
          r_byte_vld <= 1'b1;
        end
      end else if (r_bitcnt != 3'd0) begin
        if (r_idle == IW'(IDLE_CYC - 1)) begin
          r_bitcnt <= '0;
          r_idle   <= '0;
          r_abort  <= 1'b1;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end else begin
        r_idle <= '0;
      end
    end
  end

  // ---------------- command decoder ----------------
  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cmd, r_phi, r_hi, r_madctl, r_colmod;
  logic [2:0]  r_pcnt;
  logic [15:0] r_xs, r_xe, r_ys, r_ye, r_x, r_y;
  logic        r_sleep, r_disp_on, r_inv, r_err, r_we;
  logic [15:0] r_waddr, r_wdata;
  logic        w_cmd, w_dat, w_soft, w_in_win;
  logic [7:0]  w_ax, w_ay;
  logic        w_unused;

  assign w_cmd    = r_byte_vld & ~r_byte_dc;
  assign w_dat    = r_byte_vld & r_byte_dc;
  assign w_soft   = ~w_res_n | (w_cmd & (r_byte == 8'h01));
  assign w_in_win = (r_x <= MAX_XY) && (r_y <= MAX_XY);
  assign w_unused = ^{r_colmod, r_madctl};

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_state_nxt = r_state;
    if (w_cmd) begin
      case (r_byte)
        8'h2A, 8'h2B, 8'h3A, 8'h36: w_state_nxt = S_PARAM;
        8'h2C:                      w_state_nxt = S_RAMWR_HI;
        default:                    w_state_nxt = S_IDLE;
      endcase
    end else if (w_dat) begin
      case (r_state)
        S_RAMWR_HI: w_state_nxt = S_RAMWR_LO;
        S_RAMWR_LO: w_state_nxt = S_RAMWR_HI;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n)     r_state <= S_IDLE;
    else if (!w_res_n) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Output address mapping happens after the clip test on the raw x/y counters.
  always_comb begin
    w_ax = r_x[7:0];
    w_ay = r_y[7:0];
`ifdef ST7789_RX_MADCTL_EN
    if (r_madctl[5]) begin
      w_ax = r_y[7:0];
      w_ay = r_x[7:0];
    end
    if (r_madctl[6]) w_ax = 8'd239 - w_ax;
    if (r_madctl[7]) w_ay = 8'd239 - w_ay;
`endif
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cmd     <= '0;
      r_phi     <= '0;
      r_hi      <= '0;
      r_pcnt    <= '0;
      r_xs      <= '0;
      r_xe      <= MAX_XY;
      r_ys      <= '0;
      r_ye      <= MAX_XY;
      r_x       <= '0;
      r_y       <= '0;
      r_madctl  <= 8'h00;
      r_colmod  <= 8'h66;
      r_sleep   <= 1'b1;
      r_disp_on <= 1'b0;
      r_inv     <= 1'b0;
      r_err     <= 1'b0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_abort) r_err <= 1'b1;

      if (w_soft) begin
        r_xs      <= '0;
        r_xe      <= MAX_XY;
        r_ys      <= '0;
        r_ye      <= MAX_XY;
        r_madctl  <= 8'h00;
        r_colmod  <= 8'h66;
        r_sleep   <= 1'b1;
        r_disp_on <= 1'b0;
        r_inv     <= 1'b0;
      end else if (w_cmd) begin
        r_cmd  <= r_byte;
        r_pcnt <= '0;
        case (r_byte)
          8'h11: r_sleep   <= 1'b0;
          8'h10: r_sleep   <= 1'b1;
          8'h29: r_disp_on <= 1'b1;
          8'h28: r_disp_on <= 1'b0;
          8'h21: r_inv     <= 1'b1;
          8'h20: r_inv     <= 1'b0;
          8'h13, 8'h2A, 8'h2B, 8'h3A, 8'h36: ;
          8'h2C: begin
            r_x <= r_xs;
            r_y <= r_ys;
          end
          default: r_err <= 1'b1;
        endcase
      end else if (w_dat) begin
        case (r_state)
          S_PARAM: begin
            if (r_pcnt != 3'd4) r_pcnt <= r_pcnt + 3'd1;
            case (r_cmd)
              8'h2A, 8'h2B: begin
                case (r_pcnt)
                  3'd0, 3'd2: r_phi <= r_byte;
                  3'd1: if (r_cmd == 8'h2A) r_xs <= {r_phi, r_byte}; else r_ys <= {r_phi, r_byte};
                  3'd3: if (r_cmd == 8'h2A) r_xe <= {r_phi, r_byte}; else r_ye <= {r_phi, r_byte};
                  default: ;
                endcase
              end
              8'h3A: if (r_pcnt == 3'd0) begin
                r_colmod <= r_byte;
                if (r_byte != 8'h55) r_err <= 1'b1;
              end
              8'h36: if (r_pcnt == 3'd0) r_madctl <= r_byte;
              default: ;
            endcase
          end
          S_RAMWR_HI: r_hi <= r_byte;
          S_RAMWR_LO: begin
            if (w_in_win) begin
              r_we    <= 1'b1;
              r_waddr <= {w_ay, w_ax};
              r_wdata <= {r_hi, r_byte};
            end
            if (r_x == r_xe) begin
              r_x <= r_xs;
              r_y <= (r_y == r_ye) ? r_ys : r_y + 16'd1;
            end else begin
              r_x <= r_x + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_we      = r_we;
  assign w_waddr   = r_waddr;
  assign w_wdata   = r_wdata;
  assign w_sleep   = r_sleep;
  assign w_disp_on = r_disp_on;
  assign w_inv     = r_inv;
  assign w_err     = r_err;

endmodule

// File: tb/tb_m_st7789_rx.sv
// Directed bench for m_st7789_rx: drives SPI mode-2 bytes and checks pixel writes through a
// scoreboard (address, data, cycle of arrival) plus status flags at fixed points.
`timescale 1ns/1ps

module tb_m_st7789_rx;

  logic        w_clk = 1'b0;
  logic        w_rst_n, sda, scl, dc, res;
  logic        w_we, w_sleep, w_disp_on, w_inv, w_err;
  logic [15:0] w_waddr, w_wdata;

  m_st7789_rx #(.IDLE_CYC(32)) dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .st7789_SDA (sda),
    .st7789_SCL (scl),
    .st7789_DC  (dc),
    .st7789_RES (res),
    .w_we       (w_we),
    .w_waddr    (w_waddr),
    .w_wdata    (w_wdata),
    .w_sleep    (w_sleep),
    .w_disp_on  (w_disp_on),
    .w_inv      (w_inv),
    .w_err      (w_err)
  );

  always #5 w_clk = ~w_clk;

  int cyc = 0;
  always @(posedge w_clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   fall_cyc = 0;
  int   hi_cyc = 2;
  int   lo_cyc = 2;

`ifdef ST7789_RX_MADCTL_EN
  localparam logic [15:0] MADCTL_ADDR = 16'hEFEF;
`else
  localparam logic [15:0] MADCTL_ADDR = 16'h0000;
`endif

  logic [8:0]  init_seq [9] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h100, 9'h021, 9'h013, 9'h029};
  logic [15:0] win_addr [5] = '{16'h050A, 16'h050B, 16'h060A, 16'h060B, 16'h050A};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge w_clk);
  endtask

  task automatic idle(input int n);
    scl = 1'b1;
    ticks(n);
  endtask

  // Data is set while SCL is high and is sampled by the panel on the falling edge.
  task automatic send_byte(input logic [7:0] b, input logic d);
    for (int i = 7; i >= 0; i--) begin
      sda = b[i];
      dc  = d;
      scl = 1'b1;
      ticks(hi_cyc);
      scl = 1'b0;
      fall_cyc = cyc;
      ticks(lo_cyc);
    end
  endtask

  task automatic cmd(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic dat(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic set_window(input logic [15:0] xs, input logic [15:0] xe,
                            input logic [15:0] ys, input logic [15:0] ye);
    cmd(8'h2A); dat(xs[15:8]); dat(xs[7:0]); dat(xe[15:8]); dat(xe[7:0]);
    cmd(8'h2B); dat(ys[15:8]); dat(ys[7:0]); dat(ye[15:8]); dat(ye[7:0]);
  endtask

  task automatic pixel(input logic [15:0] px, input bit wr, input logic [15:0] addr);
    exp_t e;
    dat(px[15:8]);
    dat(px[7:0]);
    if (wr) begin
      e.addr = addr;
      e.data = px;
      e.cyc  = fall_cyc + 4;
      sb.push_back(e);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard, on the expected cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge w_clk);
      if (w_we === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_we", 32'(w_we), 32'd0);
        end else begin
          e = sb.pop_front();
          check("we_addr", 32'(w_waddr), 32'(e.addr));
          check("we_data", 32'(w_wdata), 32'(e.data));
          check("we_latency_cyc", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish within 1ms");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    w_rst_n = 1'b0;
    sda = 1'b0;
    scl = 1'b1;
    dc  = 1'b0;
    res = 1'b1;
    ticks(3);
    check("rst_we",      32'(w_we),      32'd0);
    check("rst_waddr",   32'(w_waddr),   32'd0);
    check("rst_wdata",   32'(w_wdata),   32'd0);
    check("rst_err",     32'(w_err),     32'd0);
    check("rst_sleep",   32'(w_sleep),   32'd1);
    check("rst_disp_on", 32'(w_disp_on), 32'd0);
    check("rst_inv",     32'(w_inv),     32'd0);
    w_rst_n = 1'b1;
    idle(4);

    // Init sequence
    for (int i = 0; i < 9; i++) send_byte(init_seq[i][7:0], init_seq[i][8]);
    idle(8);
    check("init_sleep",   32'(w_sleep),   32'd0);
    check("init_disp_on", 32'(w_disp_on), 32'd1);
    check("init_inv",     32'(w_inv),     32'd1);
    check("init_err",     32'(w_err),     32'd0);

    // Two pixels at full SCL rate
    set_window(16'd0, 16'd239, 16'd0, 16'd239);
    cmd(8'h2C);
    hi_cyc = 1;
    lo_cyc = 1;
    pixel(16'hF800, 1'b1, 16'h0000);
    pixel(16'h07E0, 1'b1, 16'h0001);
    hi_cyc = 2;
    lo_cyc = 2;
    idle(10);
    check("drain_basic", 32'(sb.size()), 32'd0);

    // Window wrap
    set_window(16'd10, 16'd11, 16'd5, 16'd6);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) pixel(16'h1000 + 16'(i), 1'b1, win_addr[i]);
    idle(10);
    check("drain_wrap", 32'(sb.size()), 32'd0);

    // Clip at the right edge
    set_window(16'd238, 16'd241, 16'd0, 16'd239);
    cmd(8'h2C);
    for (int i = 0; i < 4; i++) pixel(16'h2000 + 16'(i), (i < 2), {8'h00, 8'(238 + i)});
    idle(10);
    check("drain_clip", 32'(sb.size()), 32'd0);

    // MADCTL MX|MY
    cmd(8'h36); dat(8'hC0);
    set_window(16'd0, 16'd239, 16'd0, 16'd239);
    cmd(8'h2C);
    pixel(16'hA55A, 1'b1, MADCTL_ADDR);
    idle(10);
    cmd(8'h36); dat(8'h00);
    idle(4);
    check("drain_madctl", 32'(sb.size()), 32'd0);

    // Odd high byte dropped by a new command
    cmd(8'h2C);
    dat(8'h11);
    cmd(8'h2C);
    pixel(16'h2233, 1'b1, 16'h0000);
    idle(10);
    check("drain_odd", 32'(sb.size()), 32'd0);
    check("err_before_abort", 32'(w_err), 32'd0);

    // Partial byte abort, then a clean command
    cmd(8'h28);
    idle(8);
    check("disp_off", 32'(w_disp_on), 32'd0);
    for (int i = 0; i < 5; i++) begin
      sda = 1'b1;
      dc  = 1'b0;
      scl = 1'b1;
      ticks(2);
      scl = 1'b0;
      ticks(2);
    end
    idle(40);
    check("abort_err", 32'(w_err), 32'd1);
    cmd(8'h29);
    idle(8);
    check("after_abort_disp_on", 32'(w_disp_on), 32'd1);

    // Panel reset pulse in the middle of RAMWR
    cmd(8'h2C);
    pixel(16'h4455, 1'b1, 16'h0000);
    dat(8'h66);
    idle(2);
    res = 1'b0;
    ticks(10);
    res = 1'b1;
    idle(6);
    check("res_sleep",   32'(w_sleep),   32'd1);
    check("res_disp_on", 32'(w_disp_on), 32'd0);
    check("res_inv",     32'(w_inv),     32'd0);
    check("res_err_kept", 32'(w_err),    32'd1);
    dat(8'h77);
    dat(8'h88);
    idle(10);
    check("drain_res", 32'(sb.size()), 32'd0);
    cmd(8'h2C);
    pixel(16'h99AA, 1'b1, 16'h0000);
    idle(10);
    check("drain_final", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_st7789_rx.md
# m_st7789_rx

Receive-side model of the ST7789 240x240 panel serial interface. Deserialises the 3-wire SPI stream (SPI mode 2, MSB first, DC as 9th bit), decodes the command subset the display driver emits, and turns RAMWR pixel data into framebuffer write strobes `{y,x}`/RGB565. It sits on the same `w_clk` as the transmitter and is used as a loopback checker in simulation and as a panel emulator feeding a video memory on the FPGA.

## Interface
- `IDLE_CYC`, 32: number of `w_clk` cycles without an SCL falling edge that aborts a partial byte.
- `w_clk`  in  1  main clock (100MHz); all sampling on its rising edge.
- `w_rst_n`  in  1  asynchronous, active-low reset.
- `st7789_SDA`  in  1  serial data.
- `st7789_SCL`  in  1  serial clock, idles high.
- `st7789_DC`  in  1  0 = command byte, 1 = parameter/data byte.
- `st7789_RES`  in  1  panel hardware reset, active low.
- `w_we`  out  1  one-cycle pixel write strobe.
- `w_waddr`  out  16  pixel address `{y[7:0], x[7:0]}`.
- `w_wdata`  out  16  RGB565 pixel, first byte in [15:8].
- `w_sleep`  out  1  1 = sleep mode.
- `w_disp_on`  out  1  1 = display on.
- `w_inv`  out  1  1 = inversion on.
- `w_err`  out  1  sticky protocol error flag.

## Operation
- Input capture: SDA, SCL, DC, RES each pass through a 2-flop synchroniser; SCL falling edge is detected on the synchronised copy. Each SCL level is held by the transmitter for at least one `w_clk` cycle.
- Bit shift: on each falling edge, SDA is shifted into an 8-bit register MSB first, and a 3-bit counter is incremented. On the 8th edge, DC is sampled and byte+DC is passed to the decoder as one `byte_vld` pulse. The counter then wraps to 0.
- Abort: if the counter is nonzero and `IDLE_CYC` cycles pass with no falling edge, the counter clears, the byte is discarded, and `w_err` is set.
- Decoder FSM states: IDLE, PARAM, RAMWR_HI, RAMWR_LO.
  - Any DC=0 byte leaves the current state, drops any pending odd pixel byte, and dispatches the new command:
    - 0x01 SWRESET: applies the soft defaults.
    - 0x11 SLPOUT: sleep=0.
    - 0x10 SLPIN: sleep=1.
    - 0x29: disp_on=1.
    - 0x28: disp_on=0.
    - 0x21: inv=1.
    - 0x20: inv=0.
    - 0x13: no-op.
    - 0x2A CASET: enters PARAM, expects 4 params.
    - 0x2B RASET: enters PARAM, expects 4 params.
    - 0x3A COLMOD: enters PARAM, expects 1 param.
    - 0x36 MADCTL: enters PARAM, expects 1 param.
    - 0x2C RAMWR: sets x=XS, y=YS, then enters RAMWR_HI.
    - Any other command: sets `w_err`, goes to IDLE.
  - PARAM: parameters are collected big-endian; XS and XE for CASET, YS and YE for RASET. Each 16-bit value latches when its low byte arrives. Parameters beyond the expected count are ignored.
  - COLMOD: a value other than 0x55 sets `w_err`; RAMWR still packs 16 bits per pixel.
  - RAMWR_HI: latches the high byte, then goes to RAMWR_LO.
  - RAMWR_LO: forms the pixel and issues a write, then returns to RAMWR_HI.
- Address advance after each pixel:
  - if x==XE: x=XS, and y advances (y==YE wraps to YS);
  - otherwise x=x+1.
  - x and y are 16-bit counters.
- Clipping: a pixel with x>239 or y>239 advances the address but produces no `w_we`.
- Soft defaults (reset, `st7789_RES` low, SWRESET): XS=YS=0, XE=YE=239, MADCTL=0x00, COLMOD=0x66, sleep=1, disp_on=0, inv=0, FSM=IDLE, bit counter=0. `w_err` clears only on `w_rst_n`.
- `st7789_RES` low (synchronised) holds everything in soft defaults and suppresses `w_we`. A byte that is in flight when RES falls is discarded.

## Timing
- Reset values:
  - `w_we`=0, `w_waddr`=0, `w_wdata`=0, `w_err`=0.
  - `w_sleep`=1, `w_disp_on`=0, `w_inv`=0.
- Latency: `byte_vld` occurs 3 `w_clk` cycles after the first cycle in which raw SCL reads low on the 8th falling edge. Decode registers on the next cycle.
  - For pixels, `w_we`/`w_waddr`/`w_wdata` are valid 4 cycles after the 16th falling edge.
  - Status outputs update at the same point.
- `w_we` is high for exactly 1 cycle per pixel. `w_waddr`/`w_wdata` hold until the next pixel.
- Throughput: one byte per 16 `w_clk` cycles (SCL at 50MHz) is accepted without loss.

## Configuration
- `ST7789_RX_MADCTL_EN` defined: MADCTL bits are applied to the output address after clipping, in this order:
  - bit 5 MV swaps x and y;
  - bit 6 MX maps x to 239-x;
  - bit 7 MY maps y to 239-y.
- Not defined: MADCTL is parsed and stored but ignored; `w_waddr`={y,x}.

## Test plan
- Init sequence 01, 11, 3A 55, 36 00, 21, 13, 29 -> `w_sleep`=0, `w_disp_on`=1, `w_inv`=1, `w_err`=0, no `w_we`.
- CASET 00 00 00 EF, RASET 00 00 00 EF, RAMWR, F8 00 07 E0 -> two pulses: (0x0000, 0xF800), then (0x0001, 0x07E0), each 4 cycles after its 16th falling edge.
- Window wrap and clip:
  - CASET 0..0x0A to 0x0B, RASET 5..6, RAMWR with 5 pixels -> addresses 0x050A, 0x050B, 0x060A, 0x060B, 0x050A.
  - CASET 238..241 with 4 pixels -> only 2 `w_we`, at x=238 and x=239.
- Robustness:
  - 5 falling edges then 40 idle cycles -> `w_err`=1, and the following byte 0x29 decodes correctly.
  - Command 0x2C sent after only a high pixel byte -> that byte is dropped with no write.
- MADCTL: 36 C0, full window, RAMWR, one pixel -> `w_waddr`=0xEFEF with `ST7789_RX_MADCTL_EN`, 0x0000 without.
- `st7789_RES` low for 10 cycles in the middle of RAMWR -> no further `w_we`, status returns to defaults, and pixel bytes after RES rises produce no writes until a new RAMWR.
